route_cntrl: RTL
================

ROUTE_CNTRL -- requirements
Module: route_cntrl

Interface
REQ-001 SHALL have parameter ID_W, default 6: station ID width; command width is ID_W+2.
REQ-002 SHALL have parameter DEPTH, default 4 (power of 2, >=2): destination queue depth.
REQ-003 SHALL have parameter BUZZ_PERIOD, default 12500 (even, >=4): buzzer period in clk cycles.
REQ-004 SHALL have parameter DWELL_CYC, default 1024 (>=1): dwell time at an intermediate stop, in clk cycles.
REQ-005 SHALL have port clk  input  1  system clock, rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd  input  ID_W+2  command; [ID_W+1:ID_W]=opcode, [ID_W-1:0]=destination ID.
REQ-008 SHALL have port cmd_rdy  input  1  cmd valid.
REQ-009 SHALL have port ID  input  ID_W  station ID read at track side.
REQ-010 SHALL have port ID_vld  input  1  ID valid.
REQ-011 SHALL have port OK2Move  input  1  low = obstacle ahead.
REQ-012 SHALL have port clr_cmd_rdy  output  1  consume cmd.
REQ-013 SHALL have port clr_ID_vld  output  1  consume ID.
REQ-014 SHALL have port in_transit  output  1  route active, moving phase.
REQ-015 SHALL have port go  output  1  drive motion forward.
REQ-016 SHALL have ports buzz, buzz_n  output  1 each  piezo drive, complementary.
REQ-017 SHALL have port arrived  output  1  one-cycle pulse on reaching any queued destination.
REQ-018 SHALL have port cmd_err  output  1  one-cycle pulse on dropped APPEND (queue full) or reserved opcode.
REQ-019 SHALL have port q_cnt  output  $clog2(DEPTH)+1  queued destination count.
REQ-020 SHALL have port cur_dest  output  ID_W  queue head; 0 when queue empty.

Function
REQ-021 Opcodes SHALL be: 00 STOP, 01 GO, 10 APPEND, 11 reserved.
REQ-022 clr_cmd_rdy SHALL equal cmd_rdy combinationally (every command consumed same cycle); clr_ID_vld SHALL equal ID_vld combinationally.
REQ-023 Command and ID effects (queue, state, pulses) SHALL take effect at the clock edge ending the cycle in which cmd_rdy/ID_vld is high.
REQ-024 States SHALL be IDLE, MOVE, DWELL; in_transit SHALL be registered, 1 exactly when state is MOVE.
REQ-025 STOP in any state: flush queue (q_cnt=0), next state IDLE.
REQ-026 GO in any state: flush queue, load cmd ID as sole entry (q_cnt=1), next state MOVE; DWELL timer cleared.
REQ-027 APPEND: if q_cnt<DEPTH enqueue at tail; if IDLE, next state MOVE; if q_cnt==DEPTH drop entry, pulse cmd_err, state unchanged.
REQ-028 Reserved opcode: no state/queue change, pulse cmd_err.
REQ-029 MOVE with ID_vld and ID==cur_dest: pop head, pulse arrived; next state IDLE if queue becomes empty, else DWELL.
REQ-030 ID_vld with ID!=cur_dest, or any ID_vld outside MOVE: consumed, no other effect.
REQ-031 DWELL: count DWELL_CYC cycles from entry, then MOVE; in_transit=0 throughout.
REQ-032 Simultaneous cmd_rdy and ID_vld: STOP or GO SHALL take priority and the ID event is discarded; APPEND and a matching ID SHALL both apply (pop and push same edge; push accepted when full since pop frees a slot; q_cnt unchanged).
REQ-033 Queue SHALL be a circular buffer with pointer wrap at DEPTH; q_cnt never exceeds DEPTH nor underflows.
REQ-034 go SHALL equal in_transit & OK2Move.
REQ-035 Buzzer counter SHALL run only when in_transit & ~OK2Move, counting 0..BUZZ_PERIOD-1 and wrapping to 0.
REQ-036 buzz SHALL be registered: 1 when enabled and counter < BUZZ_PERIOD/2, else 0 (50% duty); when disabled, counter and buzz clear to 0 next edge.
REQ-037 buzz_n SHALL equal ~buzz.

Reset
REQ-038 Asserting rst_n low SHALL immediately force: state IDLE, queue empty, pointers 0, DWELL and buzzer counters 0, buzz=0, arrived=0, cmd_err=0.
REQ-039 Reset mid-route or mid-dwell SHALL discard all queued destinations; operation resumes from IDLE on deassertion.

Verification
REQ-040 GO ID=5, then ID_vld ID=3, then ID=5 -> in_transit 1 after first edge, ID=3 ignored, arrived pulse and IDLE after ID=5, q_cnt 0.
REQ-041 GO 1, APPEND 2, APPEND 3; ID 1 -> arrived, DWELL exactly DWELL_CYC cycles with in_transit=0, then MOVE with cur_dest=2.
REQ-042 Fill queue to DEPTH, APPEND again -> cmd_err pulse, q_cnt stays DEPTH; APPEND with matching ID same cycle -> accepted, q_cnt unchanged.
REQ-043 In MOVE drop OK2Move for 2*BUZZ_PERIOD cycles -> go=0, buzz high BUZZ_PERIOD/2 cycles per period, buzz_n complementary; raise OK2Move -> buzz 0 next edge.
REQ-044 STOP with simultaneous matching ID_vld -> IDLE, queue empty, no arrived pulse; opcode 11 -> cmd_err only.
REQ-045 Assert rst_n low during DWELL with q_cnt=3 -> all outputs reset values, q_cnt 0, buzz_n 1.

Source files
------------

// File: rtl/route_cntrl.sv
// Route controller: destination queue, IDLE/MOVE/DWELL sequencing and obstacle buzzer.
// Commands and station IDs are consumed the cycle they are presented.
module route_cntrl #(
    parameter int ID_W        = 6,
    parameter int DEPTH       = 4,
    parameter int BUZZ_PERIOD = 12500,
    parameter int DWELL_CYC   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ID_W+1:0]          cmd,
    input  logic                     cmd_rdy,
    input  logic [ID_W-1:0]          ID,
    input  logic                     ID_vld,
    input  logic                     OK2Move,
    output logic                     clr_cmd_rdy,
    output logic                     clr_ID_vld,
    output logic                     in_transit,
    output logic                     go,
    output logic                     buzz,
    output logic                     buzz_n,
    output logic                     arrived,
    output logic                     cmd_err,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic [ID_W-1:0]          cur_dest
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DW_W  = $clog2(DWELL_CYC + 1);
    localparam int BZ_W  = $clog2(BUZZ_PERIOD);

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_GO     = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {IDLE, MOVE, DWELL} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [BZ_W-1:0]   buzz_cnt_q, buzz_cnt_d;
    logic              in_transit_q, in_transit_d;
    logic              buzz_q, buzz_d;
    logic              arrived_q, arrived_d;
    logic              cmd_err_q, cmd_err_d;
    logic [ID_W-1:0]   mem [DEPTH];

    logic              wr_en, push, pop, id_hit, buzz_en;
    logic              is_stop, is_go, is_append, is_rsvd;
    logic [1:0]        opcode;
    logic [ID_W-1:0]   dest;

    assign opcode    = cmd[ID_W+1:ID_W];
    assign dest      = cmd[ID_W-1:0];
    assign is_stop   = cmd_rdy && (opcode == OP_STOP);
    assign is_go     = cmd_rdy && (opcode == OP_GO);
    assign is_append = cmd_rdy && (opcode == OP_APPEND);
    assign is_rsvd   = cmd_rdy && (opcode == OP_RSVD);

    assign cur_dest = (cnt_q == '0) ? '0 : mem[rd_ptr_q];
    assign id_hit   = ID_vld && (state_q == MOVE) && (cnt_q != '0) && (ID == cur_dest);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        arrived_d = 1'b0;
        cmd_err_d = 1'b0;

        if (is_stop) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = '0;
            state_d  = IDLE;
        end else if (is_go) begin
            // Flush by jumping the head to the tail, then write the new sole entry there.
            wr_en    = 1'b1;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            cnt_d    = CNT_W'(1);
            state_d  = MOVE;
        end else begin
            pop       = id_hit;
            push      = is_append && ((cnt_q != CNT_W'(DEPTH)) || id_hit);
            cmd_err_d = is_rsvd || (is_append && !push);
            arrived_d = pop;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (pop)
                state_d = (cnt_d == '0) ? IDLE : DWELL;
            else if ((state_q == DWELL) && (dwell_cnt_q == DW_W'(DWELL_CYC - 1)))
                state_d = MOVE;
            else if ((state_q == IDLE) && push)
                state_d = MOVE;
        end

        dwell_cnt_d  = ((state_q == DWELL) && (state_d == DWELL)) ? dwell_cnt_q + DW_W'(1) : '0;
        in_transit_d = (state_d == MOVE);

        buzz_en    = in_transit_q && !OK2Move;
        buzz_d     = buzz_en && (buzz_cnt_q < BZ_W'(BUZZ_PERIOD / 2));
        buzz_cnt_d = '0;
        if (buzz_en)
            buzz_cnt_d = (buzz_cnt_q == BZ_W'(BUZZ_PERIOD - 1)) ? '0 : buzz_cnt_q + BZ_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            dwell_cnt_q  <= '0;
            buzz_cnt_q   <= '0;
            in_transit_q <= 1'b0;
            buzz_q       <= 1'b0;
            arrived_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            buzz_cnt_q   <= buzz_cnt_d;
            in_transit_q <= in_transit_d;
            buzz_q       <= buzz_d;
            arrived_q    <= arrived_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    // NOTE: queue storage has no reset; cur_dest is masked to 0 while the count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= dest;
    end

    assign clr_cmd_rdy = cmd_rdy;
    assign clr_ID_vld  = ID_vld;
    assign in_transit  = in_transit_q;
    assign go          = in_transit_q & OK2Move;
    assign buzz        = buzz_q;
    assign buzz_n      = ~buzz_q;
    assign arrived     = arrived_q;
    assign cmd_err     = cmd_err_q;
    assign q_cnt       = cnt_q;

endmodule
